fetch_queue_unit: RTL
=====================

// Module: fetch_queue_unit
// PURPOSE
//  Parametrised successor of the single-register fetch stage.
//  - Prefetches instructions into a DEPTH-entry queue so decode stalls no longer block imem.
//  - Supports PC redirects from branch and trap/jump sources.
//  - Squashes an imem read still in flight at redirect time.
//  - Sits between imem and decode; each queue entry carries {pc, ir}.
// PARAMETERS
//  WIDTH     16       instruction/address width (lc3b_word when 16)
//  DEPTH     4        queue entries; power of 2, >= 2
//  RESET_PC  16'h0000 fetch PC loaded on clr
// PORTS
//  clk           in   1        clock; all state updates on posedge
//  clr           in   1        synchronous active-high reset
//  imem_rdata    in   WIDTH    instruction data, valid when imem_resp=1
//  imem_resp     in   1        imem completes current read (same cycle allowed)
//  imem_read     out  1        read request; held with stable address until imem_resp
//  imem_address  out  WIDTH    address of the current read
//  redirect_sel  in   2        00 none; 01 br_pc; 10/11 new_pc
//  br_pc         in   WIDTH    branch target
//  new_pc        in   WIDTH    trap/jump target
//  ir_ready      in   1        decode consumes head entry this cycle (= ~stall)
//  ir_valid      out  1        queue non-empty
//  ir_out        out  WIDTH    head instruction; 0 when empty
//  pc_out        out  WIDTH    PC of head instruction; 0 when empty
//  pc_plus2_out  out  WIDTH    pc_out+2 mod 2^WIDTH; 0 when empty
//  occupancy     out  $clog2(DEPTH)+1  current entry count
// BEHAVIOUR
//  Reset:
//   - while clr=1: imem_read=0; next state is FETCH with fetch_pc=RESET_PC and queue empty.
//   - All outputs reach 0 the cycle after clr.
//  State FETCH:
//   - imem_read = (occupancy < DEPTH); imem_address = fetch_pc.
//   - Only responses raise occupancy, so a raised request cannot drop before imem_resp.
//   - On imem_resp: enqueue {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+2 (wraps FFFE->0000).
//   - The next read issues the following cycle, giving 1 instr/cycle with zero-wait imem.
//  State SQUASH:
//   - imem_read=1; imem_address = squash_addr (address of the abandoned read).
//   - On imem_resp: drop the data and return to FETCH.
//  Dequeue:
//   - Happens when ir_valid & ir_ready; head pointer advances.
//   - ir_ready while empty is ignored.
//   - Simultaneous enq+deq leaves occupancy unchanged; pointers wrap modulo DEPTH.
//  Redirect (redirect_sel != 00); has priority over enqueue:
//   - Queue flushed to empty (a same-cycle dequeue counts as consumed); fetch_pc <= target.
//   - FETCH with read pending and no resp: squash_addr <= fetch_pc; go to SQUASH.
//   - FETCH with resp in the same cycle: drop the data; stay in FETCH.
//   - SQUASH: update fetch_pc only; stay in SQUASH unless imem_resp.
//  Latency:
//   - A redirect in cycle N gives the target's read in N+1 (or after the squashed resp).
//   - With zero-wait imem, ir_valid rises in N+2.
//  Outputs ir_out, pc_out and pc_plus2_out come combinationally from the queue head.
// STRUCTURE
//  - lc3b_types gains: fetch_state_t enum {FETCH, SQUASH}.
//  - lc3b_types gains: localparams REDIR_NONE=2'b00, REDIR_BR=2'b01, REDIR_NEW=2'b10.
//  - Sub-module fetch_fifo #(WIDTH*2, DEPTH): circular buffer with wr/rd/flush and count.
//  - fetch_queue_unit holds the FSM, fetch_pc, squash_addr and redirect mux.
// TESTING
//  1. clr 2 cycles, imem_resp tied to imem_read, rdata=addr^16'hA5A5, ir_ready=1
//     -> reads at 0000,0002,0004 on consecutive cycles.
//     -> first ir_valid one cycle after the first resp, pc_out=0000, ir_out=A5A5.
//  2. ir_ready=0, zero-wait imem -> occupancy climbs to 4 and imem_read=0.
//     -> raise ir_ready for 1 cycle: occupancy 3, then read of 0008 issues.
//  3. Deep fill: zero-wait imem, ir_ready=0 for 20 cycles, then 1.
//     -> pointer wrap; no lost or duplicated instruction across 10 wraps.
//  4. imem with 3-cycle resp, redirect_sel=01, br_pc=0040 one cycle after read of 0006 starts.
//     -> imem_address stays 0006 until resp; queue empty; no enqueue.
//     -> next read at 0040; pc_out=0040.
//  5. Redirect with resp in the same cycle, redirect_sel=10, new_pc=1234
//     -> response dropped; next read at 1234; occupancy 0 next cycle.
//  6. fetch_pc=FFFE, zero-wait imem -> pc_plus2_out=0000; next read at 0000.
//  7. clr asserted while in SQUASH -> imem_read=0 during clr; then FETCH at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_unit_pkg.sv
// Shared types and constants for the prefetching fetch stage.
package fetch_queue_unit_pkg;

  typedef enum logic {
    FETCH,
    SQUASH
  } fetch_state_t;

  localparam logic [1:0] REDIR_NONE = 2'b00;
  localparam logic [1:0] REDIR_BR   = 2'b01;
  localparam logic [1:0] REDIR_NEW  = 2'b10;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// imem, redirect and decode-side signals of the fetch queue; master is the fetch unit.
interface fetch_queue_unit_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
);
  logic [WIDTH-1:0]         imem_rdata;
  logic                     imem_resp;
  logic                     imem_read;
  logic [WIDTH-1:0]         imem_address;
  logic [1:0]               redirect_sel;
  logic [WIDTH-1:0]         br_pc;
  logic [WIDTH-1:0]         new_pc;
  logic                     ir_ready;
  logic                     ir_valid;
  logic [WIDTH-1:0]         ir_out;
  logic [WIDTH-1:0]         pc_out;
  logic [WIDTH-1:0]         pc_plus2_out;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    input  imem_rdata, imem_resp, redirect_sel, br_pc, new_pc, ir_ready,
    output imem_read, imem_address, ir_valid, ir_out, pc_out, pc_plus2_out, occupancy
  );

  modport slave (
    output imem_rdata, imem_resp, redirect_sel, br_pc, new_pc, ir_ready,
    input  imem_read, imem_address, ir_valid, ir_out, pc_out, pc_plus2_out, occupancy
  );
endinterface

// File: rtl/fetch_queue_unit_fifo.sv
// Circular buffer holding {pc, ir} entries; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign wr_en   = wr_i & ~full_o;
  assign rd_en   = rd_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/fetch_queue_unit.sv
// Prefetching fetch stage: fetch FSM, redirect mux and squash of in-flight imem reads.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned     WIDTH    = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                clr,
  fetch_queue_unit_if.master  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] squash_addr_q, squash_addr_d;
  logic [WIDTH-1:0] target;
  logic             redirect, read_req;
  logic             fifo_wr, fifo_rd, fifo_empty, fifo_full;
  logic [2*WIDTH-1:0] head;
  logic [CW-1:0]    count;

  assign redirect = (bus.redirect_sel != REDIR_NONE);
  assign target   = (bus.redirect_sel == REDIR_BR) ? bus.br_pc : bus.new_pc;

  always_comb begin
    state_d          = state_q;
    fetch_pc_d       = fetch_pc_q;
    squash_addr_d    = squash_addr_q;
    fifo_wr          = 1'b0;
    read_req         = 1'b0;
    bus.imem_address = fetch_pc_q;
    unique case (state_q)
      FETCH: begin
        // Only responses fill the queue, so a raised request stays up until resp.
        read_req = ~fifo_full & ~clr;
        if (redirect) begin
          fetch_pc_d = target;
          if (read_req && !bus.imem_resp) begin
            squash_addr_d = fetch_pc_q;
            state_d       = SQUASH;
          end
        end else if (read_req && bus.imem_resp) begin
          fifo_wr    = 1'b1;
          fetch_pc_d = fetch_pc_q + WIDTH'(2);
        end
      end
      SQUASH: begin
        read_req         = ~clr;
        bus.imem_address = squash_addr_q;
        if (redirect) fetch_pc_d = target;
        if (bus.imem_resp) state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      squash_addr_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      squash_addr_q <= squash_addr_d;
    end
  end

  assign fifo_rd = ~fifo_empty & bus.ir_ready;

  fetch_fifo #(
    .WIDTH(2*WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (clr),
    .flush_i (redirect),
    .wr_i    (fifo_wr),
    .wdata_i ({fetch_pc_q, bus.imem_rdata}),
    .rd_i    (fifo_rd),
    .rdata_o (head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign bus.imem_read    = read_req;
  assign bus.ir_valid     = ~fifo_empty;
  assign bus.occupancy    = count;
  assign bus.pc_out       = fifo_empty ? '0 : head[2*WIDTH-1:WIDTH];
  assign bus.ir_out       = fifo_empty ? '0 : head[WIDTH-1:0];
  assign bus.pc_plus2_out = fifo_empty ? '0 : head[2*WIDTH-1:WIDTH] + WIDTH'(2);
endmodule
